sram_controller: RTL and testbench
==================================

Name: sram_controller

Overview:
- Sequences a 32-bit load/store from the MEM stage onto an external 16-bit-wide asynchronous SRAM as two half-word phases with a programmable wait count.
- Drives `ready` low while an access is in flight; the top level uses `~ready` to freeze IF/ID/EXE/MEM pipeline registers.
- Replaces the single-cycle data memory between the EXE and MEM stage registers.

Parameters:
- BASE_ADDR, 1024: byte address mapped to SRAM word 0; subtracted from `address`.
- ACCESS_CYCLES, 2: cycles each half-word phase is held on the SRAM bus; legal range 1..15.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- rd_en  in  1  load request (MEM stage mem_read_en)
- wr_en  in  1  store request (MEM stage mem_write_en)
- address  in  32  byte address (ALU result)
- write_data  in  32  store data (Rm value)
- read_data  out  32  last completed load result, registered
- ready  out  1  high = no access in flight / access completing this cycle
- sram_addr  out  18  half-word address to SRAM
- sram_dq_out  out  16  write data to SRAM
- sram_dq_oe  out  1  1 = controller drives SRAM data bus
- sram_dq_in  in  16  read data from SRAM
- sram_we_n  out  1  active-low SRAM write strobe

Behaviour:
- Reset (async, any state):
  - state=IDLE, counter=0, read_data=0, latched addr/data=0.
  - sram_we_n=1, sram_dq_oe=0, sram_addr=0, sram_dq_out=0.
  - ready follows IDLE rules.
- States: IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE.
- IDLE:
  - ready = ~(rd_en | wr_en), combinational.
  - On a clock edge with a request, latch `address` and `write_data`, clear the counter, then:
    - wr_en goes to WR_LO. wr_en has priority if both are high.
    - Otherwise rd_en goes to RD_LO.
- Phase states (RD_LO, RD_HI, WR_LO, WR_HI):
  - Each lasts exactly ACCESS_CYCLES cycles. The counter increments each cycle; the phase exits on the edge where counter == ACCESS_CYCLES-1, and the counter clears on exit.
  - Transitions: LO goes to HI; HI goes to DONE.
- Address mapping:
  - word = (latched_addr - BASE_ADDR)[18:2], taken modulo 2^17 with no range check.
  - sram_addr = {word, 0} in *_LO and {word, 1} in *_HI.
  - In IDLE and DONE, sram_addr holds 0.
- Write phases:
  - sram_we_n=0 and sram_dq_oe=1 for every cycle of WR_LO/WR_HI.
  - sram_dq_out = data[15:0] in WR_LO and data[31:16] in WR_HI.
  - In all other states: we_n=1, oe=0.
- Read phases:
  - we_n=1, oe=0.
  - sram_dq_in is captured on the exit edge of RD_LO into a low-half holding register.
  - On the exit edge of RD_HI, read_data <= {sram_dq_in, low_half}.
  - read_data holds until the next load completes; stores never change it.
- DONE:
  - ready=1 for exactly one cycle; unconditionally returns to IDLE.
  - The pipeline unfreezes on this edge, so a new request is first seen in the following IDLE cycle.
- Latency:
  - ready is low for 2*ACCESS_CYCLES+1 consecutive cycles (IDLE request cycle plus both phases).
  - DONE is the (2*ACCESS_CYCLES+2)th cycle. With the default this is 6 cycles per access.
  - read_data is valid from DONE onward.
- Requests outside IDLE:
  - rd_en/wr_en/address/write_data changes are ignored.
  - Deasserting a request mid-access does not abort; the access completes.
- Reset mid-access:
  - Write strobe is released immediately (async).
  - No partial result reaches read_data.
  - A half-written SRAM word is permitted.
- Back-to-back requests: there is always at least one IDLE cycle between DONE and the next phase start.

Test Plan:
- Reset: assert rst mid-cycle -> outputs immediately reach reset values: ready=1 with no request, sram_we_n=1, sram_dq_oe=0, read_data=0.
- Store: wr_en=1, address=1028, write_data=0xDEADBEEF ->
  - Cycles 1-2: sram_addr=2, dq_out=0xBEEF, we_n=0.
  - Cycles 3-4: sram_addr=3, dq_out=0xDEAD.
  - Cycle 5: DONE, ready=1.
  - ready is low during cycles 0-4.
- Load: SRAM model holds [2]=0xBEEF, [3]=0xDEAD; rd_en=1, address=1028 -> read_data=0xDEADBEEF in DONE (cycle 5), we_n stays 1, oe stays 0 throughout.
- Priority and mid-access changes:
  - rd_en=wr_en=1 -> write sequence taken and read_data unchanged.
  - Dropping wr_en during WR_LO still completes WR_HI and DONE.
- ACCESS_CYCLES=1, back-to-back store then load at 1024 -> each access takes 4 cycles, one IDLE cycle between them, load returns the stored word.
- Reset asserted in RD_HI -> state=IDLE, read_data=0, and the next load completes normally in 6 cycles.

Source files
------------

// File: rtl/sram_controller.sv
// sram_controller: sequences 32-bit loads/stores onto a 16-bit async SRAM as two timed half-word phases
module sram_controller #(
    parameter int BASE_ADDR     = 1024,
    parameter int ACCESS_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic [17:0] sram_addr,
    output logic [15:0] sram_dq_out,
    output logic        sram_dq_oe,
    input  logic [15:0] sram_dq_in,
    output logic        sram_we_n
);
    typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE} state_t;
    localparam logic [3:0] LAST = 4'(ACCESS_CYCLES - 1);
    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] addr_q, data_q, off_in, off_q;
    logic [15:0] lo_q;
    logic        last;
    assign off_in = address - 32'(BASE_ADDR);
    assign off_q  = addr_q - 32'(BASE_ADDR);
    assign last   = cnt == LAST;
    assign ready  = (state == IDLE) ? ~(rd_en | wr_en) : (state == DONE);
    // bus outputs are registered: each edge loads the values for the state being entered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            addr_q      <= 32'd0;
            data_q      <= 32'd0;
            lo_q        <= 16'd0;
            read_data   <= 32'd0;
            sram_addr   <= 18'd0;
            sram_dq_out <= 16'd0;
            sram_dq_oe  <= 1'b0;
            sram_we_n   <= 1'b1;
        end else begin
            case (state)
                IDLE: if (rd_en | wr_en) begin
                    addr_q      <= address;
                    data_q      <= write_data;
                    cnt         <= 4'd0;
                    state       <= wr_en ? WR_LO : RD_LO;
                    sram_addr   <= {off_in[18:2], 1'b0};
                    sram_we_n   <= ~wr_en;
                    sram_dq_oe  <= wr_en;
                    sram_dq_out <= wr_en ? write_data[15:0] : 16'd0;
                end
                RD_LO, WR_LO: if (last) begin
                    cnt         <= 4'd0;
                    state       <= (state == WR_LO) ? WR_HI : RD_HI;
                    sram_addr   <= {off_q[18:2], 1'b1};
                    sram_dq_out <= (state == WR_LO) ? data_q[31:16] : 16'd0;
                    lo_q        <= (state == RD_LO) ? sram_dq_in : lo_q;
                end else begin
                    cnt <= cnt + 4'd1;
                end
                RD_HI, WR_HI: if (last) begin
                    cnt         <= 4'd0;
                    state       <= DONE;
                    sram_addr   <= 18'd0;
                    sram_dq_out <= 16'd0;
                    sram_dq_oe  <= 1'b0;
                    sram_we_n   <= 1'b1;
                    read_data   <= (state == RD_HI) ? {sram_dq_in, lo_q} : read_data;
                end else begin
                    cnt <= cnt + 4'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sram_controller.sv
// tb_sram_controller: cycle-indexed access model plus directed literal checks for two wait-count configurations
module tb_sram_controller;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        rd0, wr0, rd1, wr1;
    logic [31:0] a0, d0, a1, d1, rdata0, rdata1;
    logic        ready0, ready1, soe0, soe1, swen0, swen1;
    logic [17:0] saddr0, saddr1;
    logic [15:0] sdqo0, sdqo1, sdqi0, sdqi1;
    logic [15:0] mem0 [256];
    logic [15:0] mem1 [256];

    assign sdqi0 = mem0[saddr0[7:0]];
    assign sdqi1 = mem1[saddr1[7:0]];
    always @(posedge clk) begin
        if (!swen0 && soe0) mem0[saddr0[7:0]] <= sdqo0;
        if (!swen1 && soe1) mem1[saddr1[7:0]] <= sdqo1;
    end

    sram_controller #(.BASE_ADDR(1024), .ACCESS_CYCLES(2)) dut0 (
        .clk(clk), .rst(rst), .rd_en(rd0), .wr_en(wr0), .address(a0), .write_data(d0),
        .read_data(rdata0), .ready(ready0), .sram_addr(saddr0), .sram_dq_out(sdqo0),
        .sram_dq_oe(soe0), .sram_dq_in(sdqi0), .sram_we_n(swen0));
    sram_controller #(.BASE_ADDR(1024), .ACCESS_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .rd_en(rd1), .wr_en(wr1), .address(a1), .write_data(d1),
        .read_data(rdata1), .ready(ready1), .sram_addr(saddr1), .sram_dq_out(sdqo1),
        .sram_dq_oe(soe1), .sram_dq_in(sdqi1), .sram_we_n(swen1));

    int checks = 0;
    int errors = 0;
    int          acs [2] = '{2, 1};
    int          k [2];
    logic        busy [2];
    logic        iswr [2];
    logic [31:0] la [2];
    logic [31:0] ld [2];
    logic [31:0] exp_rd [2];
    logic [31:0] refm [2][128];
    logic        s_ready, s_we, s_oe, t_ready, t_we;
    logic [17:0] s_addr, t_addr;
    logic [15:0] s_dq, t_dq;
    logic [31:0] s_rd, t_rd;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // cycle 0 is the IDLE request cycle; 1..n low phase, n+1..2n high phase, 2n+1 DONE
    task automatic model(input int i, input logic r, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic o_ready, input logic o_we,
                         input logic o_oe, input logic [17:0] o_addr, input logic [15:0] o_dq,
                         input logic [31:0] o_rd);
        int n;
        logic [31:0] off;
        logic [16:0] wd;
        logic e_ready, ph;
        logic [17:0] e_addr;
        logic [15:0] e_dq;
        n = acs[i];
        if (rst) begin
            busy[i] = 1'b0;
            exp_rd[i] = 32'd0;
        end
        off = la[i] - 32'd1024;
        wd = off[18:2];
        e_ready = busy[i] ? (k[i] > 2 * n) : !(r | w);
        ph = busy[i] && k[i] <= 2 * n;
        e_addr = ph ? {wd, k[i] > n} : 18'd0;
        e_dq = (k[i] > n) ? ld[i][31:16] : ld[i][15:0];
        if (busy[i] && k[i] == 2 * n + 1 && !iswr[i]) exp_rd[i] = refm[i][wd[6:0]];
        chk($sformatf("dut%0d ready", i), {31'd0, o_ready}, {31'd0, e_ready});
        chk($sformatf("dut%0d sram_addr", i), {14'd0, o_addr}, {14'd0, e_addr});
        chk($sformatf("dut%0d we_n", i), {31'd0, o_we}, {31'd0, !(ph && iswr[i])});
        chk($sformatf("dut%0d dq_oe", i), {31'd0, o_oe}, {31'd0, ph && iswr[i]});
        chk($sformatf("dut%0d read_data", i), o_rd, exp_rd[i]);
        if (ph && iswr[i]) chk($sformatf("dut%0d dq_out", i), {16'd0, o_dq}, {16'd0, e_dq});
        if (!rst) begin
            if (!busy[i] && (r | w)) begin
                busy[i] = 1'b1;
                k[i] = 1;
                la[i] = a;
                ld[i] = d;
                iswr[i] = w;
            end else if (busy[i]) begin
                if (k[i] == 2 * n + 1) begin
                    busy[i] = 1'b0;
                    if (iswr[i]) refm[i][wd[6:0]] = ld[i];
                end else begin
                    k[i]++;
                end
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        s_ready = ready0; s_we = swen0; s_oe = soe0; s_addr = saddr0; s_dq = sdqo0; s_rd = rdata0;
        t_ready = ready1; t_we = swen1; t_addr = saddr1; t_dq = sdqo1; t_rd = rdata1;
        model(0, rd0, wr0, a0, d0, ready0, swen0, soe0, saddr0, sdqo0, rdata0);
        model(1, rd1, wr1, a1, d1, ready1, swen1, soe1, saddr1, sdqo1, rdata1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            busy[i] = 1'b0; k[i] = 0; iswr[i] = 1'b0; la[i] = 32'd0; ld[i] = 32'd0; exp_rd[i] = 32'd0;
            for (int j = 0; j < 128; j++) refm[i][j] = 32'd0;
        end
        for (int j = 0; j < 256; j++) begin
            mem0[j] = 16'd0;
            mem1[j] = 16'd0;
        end
        rst = 1'b1;
        {rd0, wr0, rd1, wr1} = 4'b0;
        a0 = 0; d0 = 0; a1 = 0; d1 = 0;
        step(); step();
        chk("reset ready", {31'd0, s_ready}, 32'd1);
        chk("reset we_n", {31'd0, s_we}, 32'd1);
        chk("reset oe", {31'd0, s_oe}, 32'd0);
        chk("reset read_data", s_rd, 32'd0);
        rst = 1'b0;
        step();

        wr0 = 1'b1; a0 = 1028; d0 = 32'hDEADBEEF;
        step();
        chk("store c0 ready", {31'd0, s_ready}, 32'd0);
        for (int c = 1; c <= 5; c++) begin
            step();
            if (c < 5) chk($sformatf("store c%0d ready", c), {31'd0, s_ready}, 32'd0);
            if (c <= 2) begin
                chk($sformatf("store c%0d addr", c), {14'd0, s_addr}, 32'd2);
                chk($sformatf("store c%0d dq", c), {16'd0, s_dq}, 32'h0000BEEF);
                chk($sformatf("store c%0d we_n", c), {31'd0, s_we}, 32'd0);
            end else if (c <= 4) begin
                chk($sformatf("store c%0d addr", c), {14'd0, s_addr}, 32'd3);
                chk($sformatf("store c%0d dq", c), {16'd0, s_dq}, 32'h0000DEAD);
            end else begin
                chk("store done ready", {31'd0, s_ready}, 32'd1);
            end
        end
        wr0 = 1'b0;
        chk("sram word2", {16'd0, mem0[2]}, 32'h0000BEEF);
        chk("sram word3", {16'd0, mem0[3]}, 32'h0000DEAD);

        rd0 = 1'b1; a0 = 1028;
        step();
        for (int c = 1; c <= 5; c++) begin
            step();
            chk($sformatf("load c%0d we_n", c), {31'd0, s_we}, 32'd1);
            chk($sformatf("load c%0d oe", c), {31'd0, s_oe}, 32'd0);
        end
        chk("load done ready", {31'd0, s_ready}, 32'd1);
        chk("load read_data", s_rd, 32'hDEADBEEF);
        rd0 = 1'b0;

        rd0 = 1'b1; wr0 = 1'b1; a0 = 1044; d0 = 32'hCAFEF00D;
        step();
        rd0 = 1'b0; wr0 = 1'b0;
        step(); step(); step();
        chk("prio c3 we_n", {31'd0, s_we}, 32'd0);
        chk("prio c3 dq", {16'd0, s_dq}, 32'h0000CAFE);
        step(); step();
        chk("prio done ready", {31'd0, s_ready}, 32'd1);
        chk("prio read_data kept", s_rd, 32'hDEADBEEF);

        rd0 = 1'b1; a0 = 1044;
        for (int c = 0; c <= 5; c++) step();
        chk("load2 read_data", s_rd, 32'hCAFEF00D);
        rd0 = 1'b0;

        rd0 = 1'b1; a0 = 1028;
        step(); step(); step();
        rd0 = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rst rd_hi read_data", rdata0, 32'd0);
        chk("rst rd_hi ready", {31'd0, ready0}, 32'd1);
        step();
        rst = 1'b0;
        step();
        rd0 = 1'b1; a0 = 1028;
        step();
        for (int c = 1; c <= 5; c++) begin
            step();
            if (c < 5) chk($sformatf("reload c%0d ready", c), {31'd0, s_ready}, 32'd0);
        end
        chk("reload done ready", {31'd0, s_ready}, 32'd1);
        chk("reload read_data", s_rd, 32'hDEADBEEF);
        rd0 = 1'b0;

        wr0 = 1'b1; a0 = 1100; d0 = 32'h55AA33CC;
        step(); step();
        chk("wr strobe before rst", {31'd0, s_we}, 32'd0);
        wr0 = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rst async we_n", {31'd0, swen0}, 32'd1);
        chk("rst async oe", {31'd0, soe0}, 32'd0);
        chk("rst async ready", {31'd0, ready0}, 32'd1);
        chk("rst async read_data", rdata0, 32'd0);
        step();
        rst = 1'b0;
        step();

        wr1 = 1'b1; a1 = 1024; d1 = 32'h0BADC0DE;
        step();
        chk("ac1 c0 ready", {31'd0, t_ready}, 32'd0);
        step();
        chk("ac1 c1 addr", {14'd0, t_addr}, 32'd0);
        chk("ac1 c1 dq", {16'd0, t_dq}, 32'h0000C0DE);
        chk("ac1 c1 we_n", {31'd0, t_we}, 32'd0);
        step();
        chk("ac1 c2 addr", {14'd0, t_addr}, 32'd1);
        chk("ac1 c2 dq", {16'd0, t_dq}, 32'h00000BAD);
        step();
        chk("ac1 c3 done", {31'd0, t_ready}, 32'd1);
        wr1 = 1'b0; rd1 = 1'b1;
        step();
        chk("ac1 c4 idle ready", {31'd0, t_ready}, 32'd0);
        chk("ac1 c4 idle addr", {14'd0, t_addr}, 32'd0);
        step(); step(); step();
        chk("ac1 c7 done", {31'd0, t_ready}, 32'd1);
        chk("ac1 read_data", t_rd, 32'h0BADC0DE);
        rd1 = 1'b0;
        step(); step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
